// File: rtl/brisc_pkg.sv
// Shared constants and types for the memory side of the brisc cache system.
package brisc_pkg;

  localparam int MEM_LATENCY     = 5;
  localparam int MEM_DEPTH_LINES = 4096;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_BUSY,
    MEM_RESP
  } mem_state_e;

endpackage

// File: rtl/main_memory_mem_array.sv
// Single-port synchronous line RAM with registered read data and no reset.
module mem_array #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 4096
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/main_memory.sv
// Line-granular main-memory responder: one outstanding request, fixed latency.
// Optional MAIN_MEMORY_WRITE_ACK_EN: writes also produce a one-cycle resp pulse.
module main_memory #(
  parameter int ADDR_WIDTH      = 32,
  parameter int LINE_WIDTH      = 128,
  parameter int MEM_DEPTH_LINES = brisc_pkg::MEM_DEPTH_LINES,
  parameter int LATENCY         = brisc_pkg::MEM_LATENCY
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LINE_WIDTH-1:0] req_data,
  input  logic                  req_write,
  output logic                  busy,
  output logic                  resp,
  output logic [LINE_WIDTH-1:0] resp_data,
  output logic [ADDR_WIDTH-1:0] resp_addr
);
  import brisc_pkg::*;

  localparam int OFS   = $clog2(LINE_WIDTH / 8);
  localparam int IDX_W = $clog2(MEM_DEPTH_LINES);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFS;

  mem_state_e            state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [LINE_WIDTH-1:0] data_reg, data_next;
  logic                  write_reg, write_next;
  logic                  busy_reg, busy_next;
  logic                  resp_reg, resp_next;
  logic [LINE_WIDTH-1:0] resp_data_reg, resp_data_next;
  logic [ADDR_WIDTH-1:0] resp_addr_reg, resp_addr_next;
  logic                  mem_we;
  logic [LINE_WIDTH-1:0] mem_rdata;

  // Index follows addr_next so the RAM starts reading the new line on the
  // accepting edge; this keeps LATENCY=1 correct despite the registered read.
  mem_array #(
    .DATA_WIDTH (LINE_WIDTH),
    .DEPTH      (MEM_DEPTH_LINES)
  ) u_mem_array (
    .clk   (clk),
    .we    (mem_we),
    .idx   (addr_next[OFS +: IDX_W]),
    .wdata (data_reg),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= MEM_IDLE;
      cnt_reg       <= '0;
      addr_reg      <= '0;
      data_reg      <= '0;
      write_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      resp_reg      <= 1'b0;
      resp_data_reg <= '0;
      resp_addr_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
      write_reg     <= write_next;
      busy_reg      <= busy_next;
      resp_reg      <= resp_next;
      resp_data_reg <= resp_data_next;
      resp_addr_reg <= resp_addr_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    addr_next      = addr_reg;
    data_next      = data_reg;
    write_next     = write_reg;
    busy_next      = busy_reg;
    resp_next      = resp_reg;
    resp_data_next = resp_data_reg;
    resp_addr_next = resp_addr_reg;
    mem_we         = 1'b0;
    case (state_reg)
      MEM_IDLE: begin
        if (req) begin
          state_next = MEM_BUSY;
          cnt_next   = CNT_W'(LATENCY - 1);
          addr_next  = req_addr & LINE_MASK;
          data_next  = req_data;
          write_next = req_write;
          busy_next  = 1'b1;
        end
      end
      MEM_BUSY: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else if (write_reg) begin
          mem_we = 1'b1;
`ifdef MAIN_MEMORY_WRITE_ACK_EN
          state_next = MEM_RESP;
`else
          state_next = MEM_IDLE;
          busy_next  = 1'b0;
`endif
        end else begin
          state_next     = MEM_RESP;
          resp_next      = 1'b1;
          resp_data_next = mem_rdata;
          resp_addr_next = addr_reg;
        end
      end
      MEM_RESP: begin
`ifdef MAIN_MEMORY_WRITE_ACK_EN
        // A write enters RESP with resp low and pulses it one cycle later.
        if (write_reg && !resp_reg) begin
          resp_next      = 1'b1;
          resp_data_next = data_reg;
          resp_addr_next = addr_reg;
        end else begin
          state_next = MEM_IDLE;
          resp_next  = 1'b0;
          busy_next  = 1'b0;
        end
`else
        state_next = MEM_IDLE;
        resp_next  = 1'b0;
        busy_next  = 1'b0;
`endif
      end
      default: state_next = MEM_IDLE;
    endcase
  end

  assign busy      = busy_reg;
  assign resp      = resp_reg;
  assign resp_data = resp_data_reg;
  assign resp_addr = resp_addr_reg;

endmodule

// File: doc/main_memory.md
Name: main_memory

Overview:
Line-granular main-memory responder. It sits on the far side of the cache/arbiter request channel. It accepts one granted line request at a time, either a read (fill) or a write (eviction). After a fixed latency it returns read lines on the response channel as a one-cycle pulse with the line-aligned address. There is one outstanding request maximum.

Parameters:
ADDR_WIDTH, ADDRESS_WIDTH (32), request/response address width
LINE_WIDTH, CACHE_LINE_WIDTH (128), line width in bits; power of two, at least 32
MEM_DEPTH_LINES, 4096, number of stored lines; power of two
LATENCY, MEM_LATENCY (5), cycles from acceptance to completion; at least 1

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req  in  1  request valid, from arbiter winner
req_addr  in  ADDR_WIDTH  request byte address
req_data  in  LINE_WIDTH  line data to write (eviction)
req_write  in  1  1 = write line, 0 = read line
busy  out  1  request in flight; new req ignored
resp  out  1  one-cycle response pulse
resp_data  out  LINE_WIDTH  line read; valid only while resp=1
resp_addr  out  ADDR_WIDTH  line-aligned address of response

Behaviour:
- Reset values: state=IDLE, cnt=0, busy=0, resp=0, resp_data=0, resp_addr=0. Array contents are not reset.
- Line index = req_addr[OFS +: log2(MEM_DEPTH_LINES)], where OFS=$clog2(LINE_WIDTH/8).
  - Low OFS bits are ignored.
  - Upper address bits are ignored, so addresses alias modulo the depth.
- FSM states: IDLE, BUSY, RESP. All outputs are registered.
- IDLE: if req=1 at edge E0, latch the request and go to BUSY.
  - Latched fields: addr with the low OFS bits zeroed, data, write.
  - cnt is loaded with LATENCY-1. busy=1 from E0.
- BUSY, cnt>0: decrement cnt.
- BUSY, cnt==0, at edge E_LATENCY:
  - Read: array[idx] goes to resp_data, latched addr goes to resp_addr, resp=1, go to RESP.
  - Write: array[idx] is written with the latched data, go to IDLE, busy=0, resp stays 0.
- RESP: resp=1 for exactly one cycle (E_L to E_L+1). Then go to IDLE with resp=0 and busy=0.
- A req seen in BUSY or RESP is ignored, not queued.
  - The requester holds req until resp for reads, or until busy falls for writes.
  - The requester must drop req in the cycle after resp. If req is still high in IDLE, it is accepted as a new request.
- Read-after-write to the same line, issued after the write has completed, returns the new data.
- resp_data and resp_addr hold their last values after resp falls.
- Reset asserted mid-operation:
  - Outputs clear immediately (async).
  - A pending write is dropped; the array is unchanged.
  - A pending read produces no response.

Optional Feature:
MAIN_MEMORY_WRITE_ACK_EN
- Defined: writes also pass through RESP. resp=1 for one cycle at E_L+1. resp_data = written line, resp_addr = line address.
- Undefined: writes complete silently as described above.

Decomposition:
- brisc_pkg gains:
  - MEM_LATENCY constant
  - MEM_DEPTH_LINES constant
  - typedef enum logic [1:0] mem_state_e {MEM_IDLE, MEM_BUSY, MEM_RESP}
- Sub-module mem_array: single-port synchronous line RAM. Write enable and index in; registered read data out; no reset. FSM and counter live in main_memory.

Test Plan:
1. Write, then read, same line:
   - Stimulus: write 0x0000_0100, data 0x11112222_33334444_55556666_77778888; wait for busy=0; read 0x0000_0108.
   - Expected: resp=1 exactly 5 cycles after the read was accepted; resp_data equals the written line; resp_addr=0x0000_0100.
2. Alias:
   - Stimulus: write 0x0001_0100 (index 0x010) with line 0xA5 repeated; read 0x0000_0100.
   - Expected: the new 0xA5 line is returned.
3. Ignore while busy:
   - Stimulus: read 0x200 accepted; pulse req at 0x300 on cycle 2.
   - Expected: exactly one resp, with resp_addr=0x200; busy=1 throughout.
4. Back-to-back:
   - Stimulus: keep req high on a new read 0x400 in the cycle after resp.
   - Expected: accepted in IDLE; second resp 5 cycles later; no extra pulses.
5. Reset mid-write:
   - Stimulus: write 0x500 with data 0xFF; assert reset at cycle 3; then read 0x500.
   - Expected: busy=0 and resp=0 immediately on reset; read returns the old content (not 0xFF).
6. Write ack:
   - With MAIN_MEMORY_WRITE_ACK_EN: write 0x600 produces resp=1 at cycle 6 with resp_addr=0x600.
   - Without it: resp stays 0.
